key_filter: RTL and testbench

KEY_FILTER -- requirements
Module: key_filter

---
 rtl/key_filter_if.sv | 22 ++
 rtl/key_filter.sv | 133 +++++++++++++
 tb/tb_key_filter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/key_filter_if.sv
// Key filter signal bundle: raw key in, debounced level and event pulses out.
// The filter connects through the slave modport; the key source uses master.
interface key_filter_if;
    logic key;
    logic key_value;
    logic key_flag;
    logic key_long;

    modport master (
        output key,
        input  key_value,
        input  key_flag,
        input  key_long
    );

    modport slave (
        input  key,
        output key_value,
        output key_flag,
        output key_long
    );
endinterface

// File: rtl/key_filter.sv
// Debounce filter for an active-low mechanical key with single-cycle change pulses.
// Optional long-press detector is enabled by defining KEY_LONG_PRESS_EN.
module key_filter #(
    parameter int unsigned DEBOUNCE_CNT = 1_000_000,
    parameter int unsigned LONG_CNT     = 50_000_000
) (
    input logic         sys_clk,
    input logic         sys_rst,
    key_filter_if.slave kif
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CNT);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CNT - 1);

    if (DEBOUNCE_CNT < 2 || DEBOUNCE_CNT > 32'd16777215) begin : g_bad_debounce
        $error("DEBOUNCE_CNT must lie in 2..2^24-1");
    end
    if (LONG_CNT < 1) begin : g_bad_long
        $error("LONG_CNT must be at least 1");
    end

    typedef enum logic [1:0] {
        StRel,
        StPressWait,
        StPrs,
        StRelWait
    } state_e;

    state_e            state_q;
    logic [1:0]        sync_q;
    logic [CntW-1:0]   cnt_q;
    logic              key_value_q;
    logic              key_flag_q;
    logic              key_s;

    assign key_s = sync_q[1];

    // Raw key enters only through sync_q; everything else sees key_s.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q      <= 2'b11;
            state_q     <= StRel;
            cnt_q       <= '0;
            key_value_q <= 1'b1;
            key_flag_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], kif.key};
            key_flag_q <= 1'b0;
            case (state_q)
                StRel: begin
                    if (!key_s) begin
                        state_q <= StPressWait;
                        cnt_q   <= '0;
                    end
                end
                StPressWait: begin
                    if (key_s) begin
                        state_q <= StRel;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q     <= StPrs;
                        cnt_q       <= '0;
                        key_value_q <= 1'b0;
                        key_flag_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StPrs: begin
                    if (key_s) begin
                        state_q <= StRelWait;
                        cnt_q   <= '0;
                    end
                end
                StRelWait: begin
                    if (!key_s) begin
                        state_q <= StPrs;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q     <= StRel;
                        cnt_q       <= '0;
                        key_value_q <= 1'b1;
                        key_flag_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StRel;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign kif.key_value = key_value_q;
    assign kif.key_flag  = key_flag_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned LongW = $clog2(LONG_CNT + 1);
    localparam logic [LongW-1:0] LongLast = LongW'(LONG_CNT - 1);
    localparam logic [LongW-1:0] LongDone = LongW'(LONG_CNT);

    logic [LongW-1:0] long_q;
    logic             key_long_q;

    // Counter parks at LONG_CNT after the pulse so each press fires at most once;
    // any cycle outside a held PRS clears it, so re-entry restarts the count.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            long_q     <= '0;
            key_long_q <= 1'b0;
        end else begin
            key_long_q <= 1'b0;
            if (state_q == StPrs && !key_s) begin
                if (long_q == LongLast) begin
                    key_long_q <= 1'b1;
                end
                if (long_q != LongDone) begin
                    long_q <= long_q + LongW'(1);
                end
            end else begin
                long_q <= '0;
            end
        end
    end

    assign kif.key_long = key_long_q;
`else
    assign kif.key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_filter.sv
// Self-checking bench for key_filter with DEBOUNCE_CNT=8, LONG_CNT=32.
// Expected flag/long events are queued at stimulus time and matched by a monitor.
module tb_key_filter;

    localparam int unsigned Deb   = 8;
    localparam int unsigned LongN = 32;
    localparam int          Lat   = Deb + 3;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   cyc     = 0;
    int   checks  = 0;
    int   failures = 0;
    int   long_seen = 0;

    key_filter_if kif ();

    key_filter #(
        .DEBOUNCE_CNT(Deb),
        .LONG_CNT    (LongN)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .kif    (kif.slave)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit val;
    } flag_ev_t;

    typedef struct {
        bit l0;
        int n0;
        bit l1;
        int n1;
        bit lf;
        int nf;
        bit exp_flag;
    } vec_t;

    flag_ev_t fq[$];
    int       lq[$];
    flag_ev_t mon_ev;
    int       mon_lc;
    vec_t     vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic drive_seg(input bit lvl, input int n, input bit expect_flag);
        flag_ev_t ev;
        if (n > 0) begin
            kif.key = lvl;
            if (expect_flag) begin
                ev.cyc = cyc + Lat;
                ev.val = lvl;
                fq.push_back(ev);
            end
            tick(n);
        end
    endtask

    task automatic drain();
        int budget = 0;
        while ((fq.size() > 0 || lq.size() > 0) && budget < 100) begin
            tick(1);
            budget++;
        end
        check("queue_drained", fq.size() + lq.size(), 0);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge sys_clk) begin
        while (fq.size() > 0 && fq[0].cyc < cyc) begin
            mon_ev = fq.pop_front();
            checks++;
            failures++;
            $display("FAIL flag_missing: no key_flag at cycle %0d, required value %0d",
                     mon_ev.cyc, mon_ev.val);
        end
        if (kif.key_flag === 1'b1) begin
            if (fq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL flag_unexpected: key_flag=1 value=%0d at cycle %0d, none required",
                         kif.key_value, cyc);
            end else begin
                mon_ev = fq.pop_front();
                check("flag_cycle", cyc, mon_ev.cyc);
                check("flag_value", int'(kif.key_value), int'(mon_ev.val));
            end
        end
        while (lq.size() > 0 && lq[0] < cyc) begin
            mon_lc = lq.pop_front();
            checks++;
            failures++;
            $display("FAIL long_missing: no key_long at cycle %0d (now %0d)", mon_lc, cyc);
        end
        if (kif.key_long !== 1'b0) begin
            long_seen++;
            if (lq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL long_unexpected: key_long=%b at cycle %0d, none required",
                         kif.key_long, cyc);
            end else begin
                mon_lc = lq.pop_front();
                check("long_cycle", cyc, mon_lc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        //          l0 n0 l1 n1 lf  nf flag
        vecs[0] = '{1, 0, 1, 0, 0, 20, 1};  // clean press
        vecs[1] = '{1, 7, 0, 0, 0, 20, 0};  // 7-cycle high glitch while pressed
        vecs[2] = '{1, 0, 1, 0, 1, 20, 1};  // clean release
        vecs[3] = '{0, 5, 1, 3, 0, 20, 1};  // bouncing press
        vecs[4] = '{1, 4, 0, 2, 1, 20, 1};  // bouncing release
        vecs[5] = '{0, 7, 1, 0, 1, 20, 0};  // 7-cycle low glitch while released
        vecs[6] = '{0, 1, 1, 1, 0, 20, 1};  // single-cycle bounce then press
        vecs[7] = '{1, 0, 1, 0, 1, 20, 1};  // release

        kif.key = 1'b1;
        sys_rst = 1'b1;
        tick(3);
        check("reset_key_value", int'(kif.key_value), 1);
        check("reset_key_flag", int'(kif.key_flag), 0);
        check("reset_key_long", int'(kif.key_long), 0);
        sys_rst = 1'b0;
        tick(5);
        check("idle_key_value", int'(kif.key_value), 1);

        for (int i = 0; i < 8; i++) begin
            drive_seg(vecs[i].l0, vecs[i].n0, 1'b0);
            drive_seg(vecs[i].l1, vecs[i].n1, 1'b0);
            drive_seg(vecs[i].lf, vecs[i].nf, vecs[i].exp_flag);
            drain();
            check($sformatf("vec%0d_key_value", i), int'(kif.key_value), int'(vecs[i].lf));
        end

        // Reset during PRESS_WAIT (count at 5) with the key still held low.
        kif.key = 1'b0;
        tick(8);
        sys_rst = 1'b1;
        tick(2);
        check("rst_abort_key_value", int'(kif.key_value), 1);
        sys_rst = 1'b0;
        fq.push_back('{cyc + Lat, 1'b0});
        tick(20);
        drain();
        check("rst_reaccept_key_value", int'(kif.key_value), 0);
        drive_seg(1'b1, 20, 1'b1);
        drain();

`ifdef KEY_LONG_PRESS_EN
        lq.push_back(cyc + Lat + int'(LongN));
        drive_seg(1'b0, 60, 1'b1);
        drive_seg(1'b1, 20, 1'b1);
        drain();

        drive_seg(1'b0, 20, 1'b1);
        drive_seg(1'b1, 20, 1'b1);
        drain();

        // Bounce out of PRS and back: long count restarts at PRS re-entry.
        drive_seg(1'b0, 25, 1'b1);
        drive_seg(1'b1, 5, 1'b0);
        kif.key = 1'b0;
        lq.push_back(cyc + 3 + int'(LongN));
        tick(45);
        drive_seg(1'b1, 20, 1'b1);
        drain();
        check("long_pulses_total", long_seen, 2);
`else
        drive_seg(1'b0, 60, 1'b1);
        drive_seg(1'b1, 20, 1'b1);
        drain();
        check("long_pulses_total", long_seen, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
